// File: rtl/clk_ctrl_pkg.sv
// Shared clock-control definitions: switch-sequencer state encoding and timer width.
package clk_ctrl_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GATE_OFF = 3'd1,
    SWITCH   = 3'd2,
    SETTLE   = 3'd3,
    GATE_ON  = 3'd4
  } state_t;

endpackage

// File: rtl/clock_switch_timer.sv
// Down-counting wait timer: loads on state entry, stops at zero, flags the final cycle.
module clock_switch_timer
  import clk_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // A load of N keeps the owning state for exactly N cycles.
  assign expired = (cnt <= CNT_W'(1));

endmodule

// File: rtl/clock_switch_seq.sv
// Glitch-free clock switch sequencer: gate off, move mux select, settle, gate on.
module clock_switch_seq
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CLOCKS    = 4,
  parameter int unsigned NUM_CLOCK_SEL = 2,
  parameter int unsigned DEFAULT_SEL   = 0,
  parameter int unsigned OFF_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [NUM_CLOCK_SEL-1:0] req_sel,
  output logic                     req_ready,
  output logic                     done,
  output logic                     err,
  output logic [NUM_CLOCK_SEL-1:0] clk_sel,
  output logic [NUM_CLOCKS-1:0]    clk_en,
  output logic                     busy,
  output logic [NUM_CLOCK_SEL-1:0] cur_sel
);

  if (NUM_CLOCKS < 2 || NUM_CLOCKS > 8) begin : g_bad_num_clocks
    $error("NUM_CLOCKS must be in 2..8");
  end
  if (NUM_CLOCK_SEL != $clog2(NUM_CLOCKS)) begin : g_bad_sel_width
    $error("NUM_CLOCK_SEL must equal clog2(NUM_CLOCKS)");
  end
  if (DEFAULT_SEL >= NUM_CLOCKS) begin : g_bad_default
    $error("DEFAULT_SEL must be below NUM_CLOCKS");
  end
  if (OFF_CYCLES < 1 || OFF_CYCLES > 255) begin : g_bad_off
    $error("OFF_CYCLES must be in 1..255");
  end
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..255");
  end

  localparam logic [NUM_CLOCK_SEL-1:0] DEF_SEL = NUM_CLOCK_SEL'(DEFAULT_SEL);
  localparam logic [NUM_CLOCKS-1:0]    DEF_EN  = NUM_CLOCKS'(1) << DEFAULT_SEL;

  state_t                   state, state_nx;
  logic [NUM_CLOCK_SEL-1:0] target;
  logic                     accept, in_range, same_sel;
  logic                     load, expired;
  logic [CNT_W-1:0]         load_val;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign in_range  = (32'(req_sel) < NUM_CLOCKS);
  assign same_sel  = (req_sel == cur_sel);

  clock_switch_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .expired  (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and timer loads; the timer is loaded on entry to each wait state.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    load_val = '0;
    case (state)
      IDLE: begin
        if (accept && in_range && !same_sel) begin
          state_nx = GATE_OFF;
          load     = 1'b1;
          load_val = CNT_W'(OFF_CYCLES);
        end
      end
      GATE_OFF: if (expired) state_nx = SWITCH;
      SWITCH: begin
        state_nx = SETTLE;
        load     = 1'b1;
        load_val = CNT_W'(SETTLE_CYCLES);
      end
      SETTLE:   if (expired) state_nx = GATE_ON;
      GATE_ON:  state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Registered mux select, gate enables and completion pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target  <= DEF_SEL;
      clk_sel <= DEF_SEL;
      cur_sel <= DEF_SEL;
      clk_en  <= DEF_EN;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            target <= req_sel;
            if (!in_range) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else if (same_sel) begin
              done <= 1'b1;
            end else begin
              clk_en <= '0;
            end
          end
        end
        SWITCH:  clk_sel <= target;
        GATE_ON: begin
          clk_en  <= NUM_CLOCKS'(1) << target;
          cur_sel <= target;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/clock_switch_seq.md
CLOCK_SWITCH_SEQ -- requirements
Module: clock_switch_seq

Interface
REQ-001 Parameter NUM_CLOCKS, default 4, number of selectable clocks, legal range 2..8.
REQ-002 Parameter NUM_CLOCK_SEL, default 2, select width, SHALL equal ceil(log2(NUM_CLOCKS)).
REQ-003 Parameter DEFAULT_SEL, default 0, clock index selected and enabled out of reset, SHALL be < NUM_CLOCKS.
REQ-004 Parameter OFF_CYCLES, default 4, clk cycles waited after gating off the old clock, range 1..255.
REQ-005 Parameter SETTLE_CYCLES, default 4, clk cycles waited after the mux select changes, range 1..255.
REQ-006 clk  input  1  always-on control clock; all logic runs on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 req_valid  input  1  switch request valid.
REQ-009 req_sel  input  NUM_CLOCK_SEL  requested clock index.
REQ-010 req_ready  output  1  high when a request is accepted this cycle.
REQ-011 done  output  1  one-cycle pulse when a request completes.
REQ-012 err  output  1  one-cycle pulse, coincident with done, for an out-of-range req_sel.
REQ-013 clk_sel  output  NUM_CLOCK_SEL  registered select to the downstream clock mux.
REQ-014 clk_en  output  NUM_CLOCKS  registered one-hot-or-zero gate enables, one per source clock.
REQ-015 busy  output  1  high whenever the FSM is not IDLE.
REQ-016 cur_sel  output  NUM_CLOCK_SEL  index of the currently enabled clock.

Function
REQ-017 FSM states SHALL be IDLE, GATE_OFF, SWITCH, SETTLE, GATE_ON.
REQ-018 req_ready SHALL equal (state == IDLE); a request is accepted when req_valid && req_ready.
REQ-019 Accepted in-range req_sel != cur_sel: IDLE->GATE_OFF; clk_en goes to all-zero on the next edge.
REQ-020 GATE_OFF SHALL hold for exactly OFF_CYCLES cycles, then go to SWITCH.
REQ-021 SWITCH SHALL last 1 cycle and register clk_sel = target; SWITCH->SETTLE.
REQ-022 SETTLE SHALL hold for exactly SETTLE_CYCLES cycles, then go to GATE_ON.
REQ-023 GATE_ON SHALL last 1 cycle: clk_en[target] and cur_sel = target are registered, done pulses, then the FSM returns to IDLE.
REQ-024 Total accept-to-done latency SHALL be OFF_CYCLES + SETTLE_CYCLES + 3 cycles.
REQ-025 Accepted req_sel == cur_sel SHALL pulse done on the next cycle without changing clk_en or clk_sel, and the FSM SHALL stay in IDLE.
REQ-026 Accepted req_sel >= NUM_CLOCKS SHALL pulse done and err on the next cycle with no state change.
REQ-027 req_valid while busy SHALL be ignored: no queuing, req_ready low.
REQ-028 The target index SHALL be latched at acceptance; req_sel changes after acceptance have no effect.
REQ-029 clk_en SHALL never have more than one bit set, and SHALL be all-zero whenever clk_sel differs from cur_sel.
REQ-030 The wait counter SHALL be 8 bits wide, load on state entry, and count down without wrap-around.

Reset
REQ-031 While rst is high, the block SHALL hold: state = IDLE, clk_sel = DEFAULT_SEL, cur_sel = DEFAULT_SEL, clk_en = one-hot(DEFAULT_SEL), done = 0, err = 0, counter = 0.
REQ-032 Reset asserted mid-switch SHALL abort the sequence immediately (asynchronously) to the REQ-031 values, with no done pulse.
REQ-033 The first request SHALL be accepted on the first clk edge after rst deasserts.

Structure
REQ-034 The state encoding typedef and the 8-bit counter width constant SHALL live in the shared clock package clk_ctrl_pkg.
REQ-035 The wait counter SHALL be the sub-module clock_switch_timer (load value, load, expired).
REQ-036 Elaboration SHALL fail if NUM_CLOCK_SEL, DEFAULT_SEL, OFF_CYCLES or SETTLE_CYCLES is out of range.

Verification
REQ-037 Reset release (defaults) -> clk_en = 4'b0001, clk_sel = 0, cur_sel = 0, req_ready = 1, busy = 0.
REQ-038 Request 2 from 0 -> clk_en = 0 for 4 cycles, clk_sel = 2, 4-cycle settle, then clk_en = 4'b0100; done exactly 11 cycles after acceptance.
REQ-039 Request 2 while cur_sel = 2 -> done on the next cycle; clk_en and clk_sel unchanged; busy stays 0.
REQ-040 NUM_CLOCKS = 3, request 3 -> done and err pulse on the next cycle; outputs unchanged.
REQ-041 Assert rst during SETTLE -> outputs immediately return to the REQ-031 defaults; no done pulse.
REQ-042 Second req_valid held during a switch -> ignored until IDLE, then accepted; an assertion checks clk_en is one-hot-or-zero on every cycle.
